// File: rtl/bus_memory_responder.sv
// Memory-side responder for the top8227 CPU bus: flop RAM window, six-byte vector
// bank, host preload port and optional read wait states driven through ready.
module bus_memory_responder #(
  parameter int          RAM_AW      = 8,
  parameter logic [15:0] RAM_BASE    = 16'h0000,
  parameter int          WAIT_STATES = 0,
  parameter logic [7:0]  OPEN_BUS    = 8'hEA,
  parameter logic [15:0] NMI_VEC     = 16'hAA00,
  parameter logic [15:0] RST_VEC     = 16'hCCF0,
  parameter logic [15:0] IRQ_VEC     = 16'hBB00
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  addressBusHigh,
  input  logic [7:0]  addressBusLow,
  input  logic        readNotWrite,
  input  logic [7:0]  dataBusOutput,
  output logic [7:0]  dataBusInput,
  output logic        ready,
  input  logic        hostWriteEnable,
  input  logic [15:0] hostAddress,
  input  logic [7:0]  hostWriteData,
  output logic        writeFault
);

  localparam int RAM_DEPTH = 1 << RAM_AW;
  localparam logic [47:0] VEC_INIT = {IRQ_VEC, RST_VEC, NMI_VEC};

  logic [15:0]       addr;
  logic              ram_hit, vec_hit, host_ram_hit, host_vec_hit;
  logic [RAM_AW-1:0] ram_idx, host_ram_idx;
  logic [2:0]        vec_idx, host_vec_idx;
  logic              cpu_write, host_same_byte;

  logic [7:0] ram [RAM_DEPTH];
  logic [7:0] vec [6];

  assign addr         = {addressBusHigh, addressBusLow};
  assign ram_hit      = (addr >> RAM_AW) == (RAM_BASE >> RAM_AW);
  assign vec_hit      = !ram_hit && (addr >= 16'hFFFA);
  assign host_ram_hit = (hostAddress >> RAM_AW) == (RAM_BASE >> RAM_AW);
  assign host_vec_hit = !host_ram_hit && (hostAddress >= 16'hFFFA);
  assign ram_idx      = addr[RAM_AW-1:0];
  assign host_ram_idx = hostAddress[RAM_AW-1:0];
  // FFFA..FFFF map onto vector slots 0..5
  assign vec_idx      = addr[2:0] - 3'd2;
  assign host_vec_idx = hostAddress[2:0] - 3'd2;
  assign cpu_write    = !readNotWrite;
  assign host_same_byte = hostWriteEnable && (hostAddress == addr) &&
                          (host_ram_hit || host_vec_hit);

  // Host assignment comes last so it overrides a CPU write to the same byte.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= 8'h00;
    end else begin
      if (cpu_write && ram_hit) ram[ram_idx] <= dataBusOutput;
      if (hostWriteEnable && host_ram_hit) ram[host_ram_idx] <= hostWriteData;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 6; i++) vec[i] <= VEC_INIT[i*8 +: 8];
    end else if (hostWriteEnable && host_vec_hit) begin
      vec[host_vec_idx] <= hostWriteData;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      writeFault <= 1'b0;
    end else if (cpu_write && !ram_hit && !host_same_byte) begin
      writeFault <= 1'b1;
    end
  end

  always_comb begin
    dataBusInput = OPEN_BUS;
    if (ram_hit)      dataBusInput = ram[ram_idx];
    else if (vec_hit) dataBusInput = vec[vec_idx];
  end

  generate
    if (WAIT_STATES > 0) begin : g_wait
      localparam logic [0:0] ST_SERVE = 1'b0;
      localparam logic [0:0] ST_WAIT  = 1'b1;
      localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);
      // With a single wait state the low cycle is the trigger cycle itself.
      localparam logic [0:0] ST_AFTER_NEW = (WAIT_STATES > 1) ? ST_WAIT : ST_SERVE;

      logic [0:0]  state_reg, state_next;
      logic [3:0]  cnt_reg, cnt_next;
      logic [15:0] prev_addr_reg;
      logic        prev_rnw_reg, prev_valid_reg;
      logic        new_read, ready_next;

      assign new_read = readNotWrite &&
                        (!prev_valid_reg || !prev_rnw_reg || (addr != prev_addr_reg));

      // cnt holds the low cycles still owed after the current one, so the
      // trigger cycle plus CNT_LOAD waiting cycles gives WAIT_STATES in total.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ready_next = 1'b1;
        if (state_reg == ST_SERVE) begin
          if (new_read) begin
            ready_next = 1'b0;
            cnt_next   = CNT_LOAD;
            state_next = ST_AFTER_NEW;
          end
        end else begin
          ready_next = 1'b0;
          if (!readNotWrite) begin
            state_next = ST_SERVE;
            cnt_next   = 4'd0;
          end else if (new_read) begin
            cnt_next   = CNT_LOAD;
            state_next = ST_AFTER_NEW;
          end else if (cnt_reg <= 4'd1) begin
            state_next = ST_SERVE;
            cnt_next   = 4'd0;
          end else begin
            cnt_next = cnt_reg - 4'd1;
          end
        end
      end

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          state_reg      <= ST_SERVE;
          cnt_reg        <= 4'd0;
          prev_addr_reg  <= 16'h0000;
          prev_rnw_reg   <= 1'b0;
          prev_valid_reg <= 1'b0;
        end else begin
          state_reg      <= state_next;
          cnt_reg        <= cnt_next;
          prev_addr_reg  <= addr;
          prev_rnw_reg   <= readNotWrite;
          prev_valid_reg <= 1'b1;
        end
      end

      assign ready = ready_next || !nrst;
    end else begin : g_no_wait
      assign ready = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder (WAIT_STATES = 3) with a per-cycle
// behavioural model of memory contents, fault flag and owed wait cycles.
module tb_bus_memory_responder;

  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [7:0]  addr_hi = 8'hFF, addr_lo = 8'hFC;
  logic        rnw = 1'b1;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic        ready;
  logic        host_we = 1'b0;
  logic [15:0] host_addr = 16'h0000;
  logic [7:0]  host_data = 8'h00;
  logic        fault;

  int checks = 0;
  int passes = 0;
  logic check_en = 1'b0;

  always #5 clk = ~clk;

  bus_memory_responder #(.WAIT_STATES(WS)) dut (
    .clk(clk), .nrst(nrst),
    .addressBusHigh(addr_hi), .addressBusLow(addr_lo),
    .readNotWrite(rnw), .dataBusOutput(wdata), .dataBusInput(rdata),
    .ready(ready), .hostWriteEnable(host_we), .hostAddress(host_addr),
    .hostWriteData(host_data), .writeFault(fault)
  );

  // Model: the visible address space, the sticky fault, and how many more
  // low cycles the current read still owes after this one.
  logic [7:0]  ram_m [256];
  logic [7:0]  vec_m [6];
  logic        fault_m;
  int          owed_m;
  logic [15:0] prev_a_m;
  logic        prev_rnw_m, prev_valid_m;
  logic [15:0] cur_a;

  assign cur_a = {addr_hi, addr_lo};

  function automatic logic [7:0] model_read(input logic [15:0] a);
    if (a < 16'h0100) return ram_m[a[7:0]];
    if (a >= 16'hFFFA) return vec_m[int'(a - 16'hFFFA)];
    return 8'hEA;
  endfunction

  function automatic logic is_new_read();
    return rnw && (!prev_valid_m || !prev_rnw_m || cur_a != prev_a_m);
  endfunction

  function automatic logic model_ready();
    if (!nrst) return 1'b1;
    if (owed_m > 0) return 1'b0;
    return !is_new_read();
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 256; i++) ram_m[i] <= 8'h00;
      vec_m        <= '{8'h00, 8'hAA, 8'hF0, 8'hCC, 8'h00, 8'hBB};
      fault_m      <= 1'b0;
      owed_m       <= 0;
      prev_a_m     <= 16'h0000;
      prev_rnw_m   <= 1'b0;
      prev_valid_m <= 1'b0;
    end else begin
      if (!rnw) begin
        if (cur_a < 16'h0100) ram_m[cur_a[7:0]] <= wdata;
        else if (!(host_we && host_addr == cur_a &&
                   (host_addr < 16'h0100 || host_addr >= 16'hFFFA))) fault_m <= 1'b1;
      end
      if (host_we) begin
        if (host_addr < 16'h0100) ram_m[host_addr[7:0]] <= host_data;
        else if (host_addr >= 16'hFFFA) vec_m[int'(host_addr - 16'hFFFA)] <= host_data;
      end
      if (owed_m > 0) begin
        if (!rnw) owed_m <= 0;
        else if (is_new_read()) owed_m <= WS - 1;
        else owed_m <= owed_m - 1;
      end else if (is_new_read()) begin
        owed_m <= WS - 1;
      end
      prev_a_m     <= cur_a;
      prev_rnw_m   <= rnw;
      prev_valid_m <= 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("cmp_data", int'(rdata), int'(model_read(cur_a)));
      check("cmp_ready", int'(ready), int'(model_ready()));
      check("cmp_fault", int'(fault), int'(fault_m));
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic r, input logic [15:0] a, input logic [7:0] d);
    rnw = r;
    {addr_hi, addr_lo} = a;
    wdata = d;
  endtask

  // Issue a read and count low-ready cycles until data is presented.
  task automatic read_wait(input logic [15:0] a, input logic [7:0] exp_d);
    int lows;
    lows = 0;
    set_bus(1'b1, a, 8'h00);
    @(negedge clk);
    while (!ready && lows < 20) begin
      lows++;
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    check($sformatf("waits_%h", a), lows, WS);
    check($sformatf("data_%h", a), int'(rdata), int'(exp_d));
    check($sformatf("ready_%h", a), int'(ready), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_fault", int'(fault), 0);
    check("rst_data_fffc", int'(rdata), 8'hF0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    read_wait(16'hFFFC, 8'hF0);
    read_wait(16'hFFFD, 8'hCC);
    read_wait(16'hFFFA, 8'h00);
    read_wait(16'hFFFB, 8'hAA);
    read_wait(16'hFFFE, 8'h00);
    read_wait(16'hFFFF, 8'hBB);
    read_wait(16'h0000, 8'h00);

    host_we = 1'b1; host_addr = 16'h0010; host_data = 8'h58;
    next_cycle();
    host_we = 1'b0;
    read_wait(16'h0010, 8'h58);
    read_wait(16'h4000, 8'hEA);

    set_bus(1'b0, 16'h0099, 8'h22);
    next_cycle();
    read_wait(16'h0099, 8'h22);
    check("fault_after_ram_write", int'(fault), 0);

    host_we = 1'b1; host_addr = 16'h0020; host_data = 8'h11;
    set_bus(1'b0, 16'h0020, 8'h77);
    next_cycle();
    host_we = 1'b0;
    read_wait(16'h0020, 8'h11);
    check("fault_after_collision", int'(fault), 0);

    read_wait(16'h0005, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_ready", int'(ready), 1);
      @(posedge clk);
      #1;
    end
    read_wait(16'h0006, 8'h00);

    set_bus(1'b1, 16'h0007, 8'h00);
    @(negedge clk);
    check("abort_first_low", int'(ready), 0);
    @(posedge clk);
    #1;
    set_bus(1'b0, 16'h0030, 8'h5A);
    next_cycle();
    set_bus(1'b0, 16'h0031, 8'h3C);
    @(negedge clk);
    check("abort_ready", int'(ready), 1);
    @(posedge clk);
    #1;
    read_wait(16'h0030, 8'h5A);
    read_wait(16'h0031, 8'h3C);

    set_bus(1'b0, 16'hFFFC, 8'h99);
    next_cycle();
    read_wait(16'hFFFC, 8'hF0);
    check("fault_set", int'(fault), 1);
    nrst = 1'b0;
    @(negedge clk);
    check("fault_cleared", int'(fault), 0);
    check("ready_in_reset", int'(ready), 1);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    set_bus(1'b1, 16'h0050, 8'h00);
    @(negedge clk);
    check("midwait_first_low", int'(ready), 0);
    @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    check("midwait_reset_ready", int'(ready), 1);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    read_wait(16'h0050, 8'h00);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
